// File: rtl/mem_access_arbiter_if.sv
// mem_access_arbiter_if: requester and memory-port signals shared by the arbiter and its neighbours.
interface mem_access_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
  logic          if_req, if_ack, d_req, d_rw, d_wb, d_ack, err, busy, mfa, read_write, word_byte, mfc;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [DW-1:0] d_wdata, rdata, mem_wdata, mem_rdata;
  modport slave (
    input  if_req, if_addr, d_req, d_rw, d_wb, d_addr, d_wdata, mem_rdata, mfc,
    output if_ack, d_ack, rdata, err, busy, mfa, read_write, word_byte, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, d_req, d_rw, d_wb, d_addr, d_wdata, mem_rdata, mfc,
    input  if_ack, d_ack, rdata, err, busy, mfa, read_write, word_byte, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: round-robin fetch/data arbiter sequencing one MFA/MFC memory port with timeout.
module mem_access_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input logic                clk,
  input logic                rst_n,
  mem_access_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} state_e;
  state_e        state_q;
  logic          ptr_q, gnt_q, if_ack_q, d_ack_q, err_q, busy_q, mfa_q, rw_q, wb_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata_q;
  logic          d_win;
  // ptr_q=1 favours the data side when both request
  assign d_win = bus.d_req && (!bus.if_req || ptr_q);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      gnt_q    <= 1'b0;
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      mfa_q    <= 1'b0;
      rw_q     <= 1'b0;
      wb_q     <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (!bus.mfc && (bus.if_req || bus.d_req)) begin
          gnt_q   <= d_win;
          addr_q  <= d_win ? bus.d_addr : bus.if_addr;
          rw_q    <= d_win ? bus.d_rw : 1'b1;
          wb_q    <= d_win ? bus.d_wb : 1'b1;
          wdata_q <= d_win ? bus.d_wdata : '0;
          busy_q  <= 1'b1;
          state_q <= ADDR;
        end
        ADDR: begin
          cnt_q   <= '0;
          mfa_q   <= 1'b1;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          // MFC takes priority over a timeout landing in the same cycle
          if (bus.mfc || cnt_q == CW'(TIMEOUT - 1)) begin
            mfa_q    <= 1'b0;
            err_q    <= !bus.mfc;
            rdata_q  <= (bus.mfc && rw_q) ? bus.mem_rdata : '0;
            if_ack_q <= !gnt_q;
            d_ack_q  <= gnt_q;
            state_q  <= DONE;
          end
        end
        DONE: begin
          if_ack_q <= 1'b0;
          d_ack_q  <= 1'b0;
          busy_q   <= 1'b0;
          ptr_q    <= !gnt_q;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.if_ack     = if_ack_q;
  assign bus.d_ack      = d_ack_q;
  assign bus.rdata      = rdata_q;
  assign bus.err        = err_q;
  assign bus.busy       = busy_q;
  assign bus.mfa        = mfa_q;
  assign bus.read_write = rw_q;
  assign bus.word_byte  = wb_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: directed vectors with hand-computed expectations for the memory arbiter.
module tb_mem_access_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   mfa_n, dly;
  logic got_i, got_d, e_o;
  logic [31:0] rd_o, w_addr, w_wdata;
  logic w_rw, w_wb;
  mem_access_arbiter_if #(.AW(32), .DW(32)) bus ();
  mem_access_arbiter #(.AW(32), .DW(32), .TIMEOUT(15)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask
  // Memory responder: MFC after lat WAIT cycles (lat<0: never); returns at the ack cycle
  task automatic serve(input int lat, input logic [31:0] rd);
    mfa_n = 0;
    dly   = 0;
    got_i = 1'b0;
    got_d = 1'b0;
    rd_o  = '0;
    e_o   = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      dly++;
      if (bus.mfa) begin
        if (mfa_n == 0) begin
          w_addr  = bus.mem_addr;
          w_wdata = bus.mem_wdata;
          w_rw    = bus.read_write;
          w_wb    = bus.word_byte;
        end
        mfa_n++;
        bus.mfc       = (lat >= 0 && mfa_n - 1 == lat);
        bus.mem_rdata = rd;
      end else bus.mfc = 1'b0;
      if (bus.if_ack || bus.d_ack) begin
        got_i = bus.if_ack;
        got_d = bus.d_ack;
        rd_o  = bus.rdata;
        e_o   = bus.err;
        break;
      end
    end
    chk("ack_seen", 32'(got_i | got_d), 32'd1);
  endtask
  initial begin
    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_rw = 0; bus.d_wb = 0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.mem_rdata = '0; bus.mfc = 0;
    do_reset();
    chk("rst_mfa", 32'(bus.mfa), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ack", 32'({bus.if_ack, bus.d_ack, bus.err}), 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_maddr", bus.mem_addr, 0);
    // Fetch read, MFC on first WAIT cycle
    bus.if_req = 1; bus.if_addr = 32'h100;
    serve(0, 32'hDEADBEEF);
    bus.if_req = 0;
    chk("t1_iack", 32'(got_i), 1);
    chk("t1_dly", 32'(dly), 3);
    chk("t1_mfa", 32'(mfa_n), 1);
    chk("t1_rdata", rd_o, 32'hDEADBEEF);
    chk("t1_err", 32'(e_o), 0);
    chk("t1_addr", w_addr, 32'h100);
    chk("t1_rwwb", 32'({w_rw, w_wb}), 32'b11);
    // Both held from reset: F,D,F,D
    do_reset();
    bus.if_req = 1; bus.d_req = 1; bus.d_rw = 1; bus.d_wb = 1; bus.d_addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      serve(1, 32'h1000 + k);
      chk($sformatf("t2_dgnt%0d", k), 32'(got_d), 32'(k % 2));
      chk($sformatf("t2_addr%0d", k), w_addr, (k % 2) ? 32'h200 : 32'h100);
    end
    bus.if_req = 0; bus.d_req = 0;
    tick();
    // Byte write
    bus.d_req = 1; bus.d_rw = 0; bus.d_wb = 0; bus.d_addr = 32'h21; bus.d_wdata = 32'hAB;
    serve(2, 32'h12345678);
    bus.d_req = 0;
    chk("t3_dack", 32'(got_d), 1);
    chk("t3_addr", w_addr, 32'h21);
    chk("t3_wdata", w_wdata, 32'hAB);
    chk("t3_rwwb", 32'({w_rw, w_wb}), 0);
    chk("t3_rdata", rd_o, 0);
    chk("t3_hold", bus.mem_addr, 32'h21);
    tick();
    // Timeout, then MFC on the last allowed cycle
    bus.d_req = 1; bus.d_rw = 1; bus.d_wb = 1; bus.d_addr = 32'h300;
    serve(-1, 32'hFFFF);
    bus.d_req = 0;
    chk("t4_mfa", 32'(mfa_n), 15);
    chk("t4_dly", 32'(dly), 17);
    chk("t4_err", 32'(e_o), 1);
    chk("t4_rdata", rd_o, 0);
    tick();
    bus.d_req = 1;
    serve(14, 32'hCAFE0001);
    bus.d_req = 0;
    chk("t4b_mfa", 32'(mfa_n), 15);
    chk("t4b_err", 32'(e_o), 0);
    chk("t4b_rdata", rd_o, 32'hCAFE0001);
    tick();
    // MFC stuck high blocks a pending request
    bus.d_req = 1;
    serve(0, 32'h55);
    bus.mfc = 1;
    for (int k = 0; k < 4; k++) tick();
    chk("t5_busy", 32'(bus.busy), 0);
    chk("t5_mfa", 32'(bus.mfa), 0);
    bus.mfc = 0;
    serve(0, 32'h66);
    bus.d_req = 0;
    chk("t5_dack", 32'(got_d), 1);
    chk("t5_rdata", rd_o, 32'h66);
    tick();
    // Point the pointer at data, then reset mid-WAIT
    bus.if_req = 1;
    serve(0, 32'h77);
    bus.if_req = 0;
    tick();
    bus.if_req = 1; bus.d_req = 1; bus.d_addr = 32'h400;
    tick();
    tick();
    chk("t6_mfa", 32'(bus.mfa), 1);
    chk("t6_dwin", bus.mem_addr, 32'h400);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rmfa", 32'(bus.mfa), 0);
    chk("t6_rbusy", 32'(bus.busy), 0);
    tick();
    chk("t6_noack", 32'({bus.if_ack, bus.d_ack}), 0);
    rst_n = 1'b1;
    serve(0, 32'h88);
    chk("t6_fetch", 32'(got_i), 1);
    chk("t6_addr", w_addr, 32'h100);
    bus.if_req = 0; bus.d_req = 0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
